// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the byte-wide data memory between the wasm parser (port 0) and the cpu (port 1).
// Optional grant-hold watchdog is built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              rd_en0,
    input  logic              rd_en1,
    input  logic              wr_en0,
    input  logic              wr_en1,
    output logic              rdy0,
    output logic              rdy1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_e;

    state_e state_q;
    logic   last_q;
    logic   gnt0_q;
    logic   gnt1_q;
    logic   timeout_err_q;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    // last_q remembers the previous owner so simultaneous requests alternate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q         <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0 && (!req1 || last_q)) begin
                        state_q <= OWN0;
                        gnt0_q  <= 1'b1;
                    end else if (req1) begin
                        state_q <= OWN1;
                        gnt1_q  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!req0) begin
                        state_q <= DRAIN;
                        last_q  <= 1'b0;
                        gnt0_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (req1) begin
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state_q       <= DRAIN;
                            last_q        <= 1'b0;
                            gnt0_q        <= 1'b0;
                            timeout_err_q <= 1'b1;
                            cnt_q         <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
                end
                OWN1: begin
                    if (!req1) begin
                        state_q <= DRAIN;
                        last_q  <= 1'b1;
                        gnt1_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (req0) begin
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state_q       <= DRAIN;
                            last_q        <= 1'b1;
                            gnt1_q        <= 1'b0;
                            timeout_err_q <= 1'b1;
                            cnt_q         <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                    end
                end
                DRAIN: begin
                    // Wait for the memory to release ready so the next owner never sees a stale one.
                    if (!mem_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        case (state_q)
            OWN0: begin
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_rd_en = rd_en0;
                mem_wr_en = wr_en0;
                rdy0      = mem_ready;
            end
            OWN1: begin
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_rd_en = rd_en1;
                mem_wr_en = wr_en1;
                rdy1      = mem_ready;
            end
            default: begin
            end
        endcase
    end

    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rdata       = mem_rdata;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: expected bus state is queued per stimulus step and compared after the clock edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic        gnt0, gnt1;
    logic [31:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        rd_en0, rd_en1, wr_en0, wr_en1;
    logic        rdy0, rdy1;
    logic [7:0]  rdata;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd_en, mem_wr_en;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    // ctl bit order: {timeout_err, gnt0, gnt1, rdy0, rdy1, mem_rd_en, mem_wr_en}
    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    exp_t sb[$];

    mem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .rd_en0     (rd_en0),
        .rd_en1     (rd_en1),
        .wr_en0     (wr_en0),
        .wr_en1     (wr_en1),
        .rdy0       (rdy0),
        .rdy1       (rdy1),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [6:0] ctlNow();
        return {timeout_err, gnt0, gnt1, rdy0, rdy1, mem_rd_en, mem_wr_en};
    endfunction

    // Queue the expectation, clock once, then pop and compare against the bus.
    task automatic applyStimulus(input string tag, input logic [6:0] ctl, input logic [31:0] addr,
                                 input logic [7:0] wdata);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.addr = addr; e.wdata = wdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checkOutput({e.tag, "_ctl"},   64'(ctlNow()),  64'(e.ctl));
        checkOutput({e.tag, "_addr"},  64'(mem_addr),  64'(e.addr));
        checkOutput({e.tag, "_wdata"}, 64'(mem_wdata), 64'(e.wdata));
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        rd_en0 = 0; rd_en1 = 0; wr_en0 = 0; wr_en1 = 0; mem_rdata = 0; mem_ready = 0;
        #1;
        checkOutput("rst_ctl",  64'(ctlNow()), 64'(7'b0));
        checkOutput("rst_addr", 64'(mem_addr), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        doReset();

        // single requester
        req0 = 1; addr0 = 32'h100; rd_en0 = 1; mem_ready = 1;
        applyStimulus("a_gnt0", 7'b0101010, 32'h100, 8'h00);
        addr0 = 32'h104;
        applyStimulus("a_follow", 7'b0101010, 32'h104, 8'h00);
        mem_rdata = 8'h3C;
        #1;
        checkOutput("a_rdata", 64'(rdata), 64'h3C);
        req0 = 0; rd_en0 = 0;
        applyStimulus("a_drain", 7'b0, 32'h0, 8'h00);
        mem_ready = 0;
        applyStimulus("a_idle", 7'b0, 32'h0, 8'h00);

        // round robin from reset
        doReset();
        req0 = 1; req1 = 1; addr0 = 32'h200; addr1 = 32'h300; mem_ready = 1;
        applyStimulus("b_first0", 7'b0101000, 32'h200, 8'h00);
        req0 = 0; mem_ready = 0;
        applyStimulus("b_drain", 7'b0, 32'h0, 8'h00);
        applyStimulus("b_idle", 7'b0, 32'h0, 8'h00);
        applyStimulus("b_gnt1", 7'b0010000, 32'h300, 8'h00);
        mem_ready = 1;
        applyStimulus("b_rdy1", 7'b0010100, 32'h300, 8'h00);
        req1 = 0; mem_ready = 0;
        applyStimulus("b_drain2", 7'b0, 32'h0, 8'h00);
        applyStimulus("b_idle2", 7'b0, 32'h0, 8'h00);
        req0 = 1; req1 = 1;
        applyStimulus("b_rr0", 7'b0100000, 32'h200, 8'h00);
        req0 = 0; req1 = 0;
        applyStimulus("b_drain3", 7'b0, 32'h0, 8'h00);
        applyStimulus("b_idle3", 7'b0, 32'h0, 8'h00);

        // drain stalls while memory still reports ready
        req1 = 1; rd_en1 = 1; addr1 = 32'h1F00; mem_ready = 1;
        applyStimulus("c_gnt1", 7'b0010110, 32'h1F00, 8'h00);
        req1 = 0; req0 = 1;
        for (int i = 0; i < 3; i++) applyStimulus("c_stall", 7'b0, 32'h0, 8'h00);
        mem_ready = 0;
        applyStimulus("c_idle", 7'b0, 32'h0, 8'h00);
        applyStimulus("c_gnt0", 7'b0100000, 32'h200, 8'h00);
        req0 = 0;
        applyStimulus("c_drain", 7'b0, 32'h0, 8'h00);
        applyStimulus("c_idle2", 7'b0, 32'h0, 8'h00);

        // enables from the port without the grant are ignored
        req1 = 1; rd_en1 = 0; wr_en1 = 0; wdata1 = 8'h55; addr1 = 32'h40;
        req0 = 1; wr_en0 = 1; wdata0 = 8'hAA; addr0 = 32'h80;
        applyStimulus("d_nowr", 7'b0010000, 32'h40, 8'h55);
        wr_en1 = 1; mem_ready = 1;
        applyStimulus("d_wr1", 7'b0010101, 32'h40, 8'h55);
        wr_en1 = 0; rd_en1 = 1;
        applyStimulus("d_rd1", 7'b0010110, 32'h40, 8'h55);

        // asynchronous reset mid-read
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("e_gnt1",  64'(gnt1),      64'(0));
        checkOutput("e_rden",  64'(mem_rd_en), 64'(0));
        checkOutput("e_rdy1",  64'(rdy1),      64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("e_after", 7'b0101001, 32'h80, 8'hAA);

        // grant held indefinitely without the watchdog
        req0 = 0; wr_en0 = 0; mem_ready = 0;
        applyStimulus("f_drain", 7'b0, 32'h0, 8'h00);
        applyStimulus("f_idle", 7'b0, 32'h0, 8'h00);
        applyStimulus("f_gnt1", 7'b0010010, 32'h40, 8'h55);
        req0 = 1;
        for (int i = 0; i < 120; i++) applyStimulus("f_hold", 7'b0010010, 32'h40, 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
